// File: rtl/cobs_cmd_decoder.sv
// Streaming COBS decoder with a mode/address/data command parser that produces
// addressed byte writes toward the VRAM write path. Bytes are handled one per accepted input.
module cobs_cmd_decoder #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  MODE_DATA = 8'h01,
    parameter logic [7:0]  MODE_ADDR = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              frame_done,
    output logic              frame_err,
    output logic [ADDR_W-1:0] cur_addr
);

    typedef enum logic {
        C_CODE,
        C_LIT
    } cobs_state_t;

    typedef enum logic [2:0] {
        P_MODE,
        P_DATA,
        P_ADDR_LO,
        P_ADDR_HI,
        P_IGNORE
    } parse_state_t;

    cobs_state_t       cobs_q, cobs_d;
    parse_state_t      parse_q, parse_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              zero_after_q, zero_after_d;
    logic              pending_zero_q, pending_zero_d;
    logic              nonempty_q, nonempty_d;
    logic [7:0]        addr_lo_q, addr_lo_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    logic              accept;
    logic              dec_valid;
    logic [7:0]        dec_byte;
    logic [15:0]       addr_full;

    assign in_ready   = !wr_valid_q || wr_ready;
    assign accept     = in_valid && in_ready;
    assign addr_full  = {dec_byte, addr_lo_q};

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign cur_addr   = cur_addr_q;

    // COBS layer: at most one decoded byte per accepted input byte.
    always_comb begin
        cobs_d         = cobs_q;
        cnt_d          = cnt_q;
        zero_after_d   = zero_after_q;
        pending_zero_d = pending_zero_q;
        frame_done_d   = 1'b0;
        frame_err_d    = 1'b0;
        dec_valid      = 1'b0;
        dec_byte       = 8'h00;
        if (accept) begin
            case (cobs_q)
                C_CODE: begin
                    if (in_data == 8'h00) begin
                        frame_done_d   = nonempty_q;
                        pending_zero_d = 1'b0;
                    end else begin
                        dec_valid    = pending_zero_q;
                        cnt_d        = in_data - 8'd1;
                        zero_after_d = (in_data != 8'hFF);
                        if (in_data == 8'h01) begin
                            pending_zero_d = 1'b1;
                        end else begin
                            pending_zero_d = 1'b0;
                            cobs_d         = C_LIT;
                        end
                    end
                end
                default: begin
                    if (in_data == 8'h00) begin
                        frame_err_d    = 1'b1;
                        pending_zero_d = 1'b0;
                        cobs_d         = C_CODE;
                    end else begin
                        dec_valid = 1'b1;
                        dec_byte  = in_data;
                        cnt_d     = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            cobs_d         = C_CODE;
                            pending_zero_d = zero_after_q;
                        end
                    end
                end
            endcase
        end
    end

    // Parser and write request register; a new write only arrives when the slot is free.
    always_comb begin
        parse_d    = parse_q;
        nonempty_d = nonempty_q;
        addr_lo_d  = addr_lo_q;
        cur_addr_d = cur_addr_q;
        wr_valid_d = wr_valid_q && !wr_ready;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (frame_done_d || frame_err_d || (accept && cobs_q == C_CODE && in_data == 8'h00)) begin
            parse_d    = P_MODE;
            nonempty_d = 1'b0;
        end
        if (dec_valid) begin
            nonempty_d = 1'b1;
            case (parse_q)
                P_MODE: begin
                    if (dec_byte == MODE_DATA) begin
                        parse_d = P_DATA;
                    end else if (dec_byte == MODE_ADDR) begin
                        parse_d = P_ADDR_LO;
                    end else begin
                        parse_d = P_IGNORE;
                    end
                end
                P_DATA: begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = cur_addr_q;
                    wr_data_d  = dec_byte;
                    cur_addr_d = cur_addr_q + 1'b1;
                end
                P_ADDR_LO: begin
                    addr_lo_d = dec_byte;
                    parse_d   = P_ADDR_HI;
                end
                P_ADDR_HI: begin
                    cur_addr_d = addr_full[ADDR_W-1:0];
                    parse_d    = P_ADDR_LO;
                end
                default: begin
                    parse_d = P_IGNORE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cobs_q         <= C_CODE;
            parse_q        <= P_MODE;
            cnt_q          <= 8'h00;
            zero_after_q   <= 1'b0;
            pending_zero_q <= 1'b0;
            nonempty_q     <= 1'b0;
            addr_lo_q      <= 8'h00;
            cur_addr_q     <= '0;
            wr_valid_q     <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= 8'h00;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            cobs_q         <= cobs_d;
            parse_q        <= parse_d;
            cnt_q          <= cnt_d;
            zero_after_q   <= zero_after_d;
            pending_zero_q <= pending_zero_d;
            nonempty_q     <= nonempty_d;
            addr_lo_q      <= addr_lo_d;
            cur_addr_q     <= cur_addr_d;
            wr_valid_q     <= wr_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_done_q   <= frame_done_d;
            frame_err_q    <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_cobs_cmd_decoder.sv
// Directed bench for cobs_cmd_decoder: frames are pushed byte by byte and the
// observed write stream, pulses and address register are compared to hand-derived values.
module tb_cobs_cmd_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] cur_addr;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [15:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          viol_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr  = 16'h0;
    logic [7:0]  prev_data  = 8'h0;

    logic [15:0] exp_a[$];
    logic [7:0]  exp_d[$];
    int          rd_idx = 0;

    cobs_cmd_decoder #(
        .ADDR_W   (16),
        .MODE_DATA(8'h01),
        .MODE_ADDR(8'h02)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .cur_addr  (cur_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe handshakes, pulses and stall behaviour using pre-edge values.
    always @(posedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) begin
                wr_addr_log.push_back(wr_addr);
                wr_data_log.push_back(wr_data);
                $display("wr addr=%04h data=%02h", wr_addr, wr_data);
            end
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            if (wr_valid && !wr_ready) begin
                if (in_ready) viol_cnt++;
                if (prev_stall && (wr_addr != prev_addr || wr_data != prev_data)) viol_cnt++;
                prev_stall = 1'b1;
                prev_addr  = wr_addr;
                prev_data  = wr_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && t < 200) begin
            @(posedge clk);
            acc = in_ready;
            t++;
        end
        check("in_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic end_input();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        end_input();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (wr_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", {31'b0, wr_valid}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, wr_addr_log.size() - rd_idx, exp_a.size());
        foreach (exp_a[i]) begin
            if (rd_idx + i < wr_addr_log.size()) begin
                check({tag, "_addr"}, {16'b0, wr_addr_log[rd_idx + i]}, {16'b0, exp_a[i]});
                check({tag, "_data"}, {24'b0, wr_data_log[rd_idx + i]}, {24'b0, exp_d[i]});
            end
        end
        rd_idx = wr_addr_log.size();
        exp_a.delete();
        exp_d.delete();
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic stall_writes();
        int t;
        t = 0;
        while (!wr_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        wr_ready = 1'b1;
    endtask

    initial begin
        int           d0;
        int           e0;
        logic [7:0]   fr[$];

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        wr_ready = 1'b1;
        #12;
        check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("rst_cur_addr", {16'b0, cur_addr}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 1: address load then data with a stuffed zero
        d0 = done_cnt; e0 = err_cnt;
        fr = '{8'h04, 8'h02, 8'h34, 8'h12, 8'h00};
        send_frame(fr);
        fr = '{8'h03, 8'h01, 8'hAA, 8'h02, 8'hBB, 8'h00};
        send_frame(fr);
        wait_idle();
        expect_wr(16'h1234, 8'hAA);
        expect_wr(16'h1235, 8'h00);
        expect_wr(16'h1236, 8'hBB);
        check_writes("c1");
        check("c1_cur", {16'b0, cur_addr}, 32'h1237);
        check("c1_done", done_cnt - d0, 32'd2);
        check("c1_err", err_cnt - e0, 32'd0);

        // 2: full 254-byte literal block, no implicit zero
        d0 = done_cnt;
        fr = '{8'hFF, 8'h01};
        for (int i = 1; i <= 253; i++) fr.push_back(8'(i));
        fr.push_back(8'h00);
        send_frame(fr);
        wait_idle();
        for (int i = 0; i < 253; i++) expect_wr(16'h1237 + 16'(i), 8'(i + 1));
        check_writes("c2");
        check("c2_cur", {16'b0, cur_addr}, 32'h1334);
        check("c2_done", done_cnt - d0, 32'd1);

        // 3: backpressure
        d0 = done_cnt;
        wr_ready = 1'b0;
        fr = '{8'h03, 8'h01, 8'hAA, 8'h02, 8'hBB, 8'h00};
        fork
            send_frame(fr);
            stall_writes();
        join
        wait_idle();
        expect_wr(16'h1334, 8'hAA);
        expect_wr(16'h1335, 8'h00);
        expect_wr(16'h1336, 8'hBB);
        check_writes("c3");
        check("c3_stall_viol", viol_cnt, 32'd0);
        check("c3_done", done_cnt - d0, 32'd1);

        // 4: aborted frame, then a normal one
        d0 = done_cnt; e0 = err_cnt;
        fr = '{8'h05, 8'h01, 8'h11, 8'h00};
        send_frame(fr);
        wait_idle();
        expect_wr(16'h1337, 8'h11);
        check_writes("c4");
        check("c4_err", err_cnt - e0, 32'd1);
        check("c4_done", done_cnt - d0, 32'd0);
        fr = '{8'h03, 8'h01, 8'h5A, 8'h00};
        send_frame(fr);
        wait_idle();
        expect_wr(16'h1338, 8'h5A);
        check_writes("c4b");
        check("c4b_done", done_cnt - d0, 32'd1);

        // 5a: address wrap
        fr = '{8'h04, 8'h02, 8'hFF, 8'hFF, 8'h00};
        send_frame(fr);
        fr = '{8'h03, 8'h01, 8'h77, 8'h00};
        send_frame(fr);
        wait_idle();
        expect_wr(16'hFFFF, 8'h77);
        check_writes("c5a");
        check("c5a_cur", {16'b0, cur_addr}, 32'h0000);

        // 5b: address pair then unpaired low byte; then low byte only
        fr = '{8'h05, 8'h02, 8'h11, 8'h22, 8'h33, 8'h00};
        send_frame(fr);
        wait_idle();
        check("c5b_reload", {16'b0, cur_addr}, 32'h2211);
        fr = '{8'h03, 8'h02, 8'h56, 8'h00};
        send_frame(fr);
        wait_idle();
        check("c5b_unpaired", {16'b0, cur_addr}, 32'h2211);
        check_writes("c5b");

        // 5c: unknown mode
        d0 = done_cnt;
        fr = '{8'h02, 8'h07, 8'h00};
        send_frame(fr);
        wait_idle();
        check_writes("c5c");
        check("c5c_done", done_cnt - d0, 32'd1);

        // 5d: lone delimiter
        d0 = done_cnt; e0 = err_cnt;
        fr = '{8'h00};
        send_frame(fr);
        wait_idle();
        check("c5d_done", done_cnt - d0, 32'd0);
        check("c5d_err", err_cnt - e0, 32'd0);

        // 6: asynchronous reset mid-frame
        send_byte(8'h03);
        send_byte(8'h01);
        #2 in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("c6_cur", {16'b0, cur_addr}, 32'h0000);
        check("c6_wr_addr", {16'b0, wr_addr}, 32'h0000);
        check("c6_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("c6_pulses", {30'b0, frame_done, frame_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fr = '{8'h03, 8'h01, 8'hCC, 8'h00};
        send_frame(fr);
        wait_idle();
        expect_wr(16'h0000, 8'hCC);
        check_writes("c6");
        check("c6_cur_after", {16'b0, cur_addr}, 32'h0001);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
